// File: rtl/engine_mode_sequencer_if.sv
// Handshake/status bundle between the mode sequencer and the engines around it.
// The master side drives start/done/ack; the sequencer (slave) drives modes and enables.
interface engine_mode_sequencer_if #(
  parameter int NUM_ENG = 3,
  parameter int MODE_W  = $clog2(NUM_ENG + 3)
);
  logic                start;
  logic [NUM_ENG-1:0]  skip_mask;
  logic                mem_done;
  logic [NUM_ENG-1:0]  eng_done;
  logic                disp_ack;
  logic [MODE_W-1:0]   mode_num;
  logic                en_mem;
  logic [NUM_ENG-1:0]  en_eng;
  logic                en_disp;
  logic                busy;
  logic                run_done;
  logic                timeout_err;
  logic [MODE_W-1:0]   err_mode;

  modport master (
    output start, skip_mask, mem_done, eng_done, disp_ack,
    input  mode_num, en_mem, en_eng, en_disp, busy, run_done, timeout_err, err_mode
  );

  modport slave (
    input  start, skip_mask, mem_done, eng_done, disp_ack,
    output mode_num, en_mem, en_eng, en_disp, busy, run_done, timeout_err, err_mode
  );
endinterface

// File: rtl/engine_mode_sequencer.sv
// Steps MEM -> unskipped engines -> DISP on done handshakes, with a per-mode watchdog
// that forces the normal advance and records the first mode that timed out.
module engine_mode_sequencer #(
  parameter int NUM_ENG = 3,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input logic                    clk,
  input logic                    rst,
  engine_mode_sequencer_if.slave bus
);
  localparam int MODE_W = $clog2(NUM_ENG + 3);

  localparam logic [MODE_W-1:0] S_IDLE = MODE_W'(0);
  localparam logic [MODE_W-1:0] S_MEM  = MODE_W'(1);
  localparam logic [MODE_W-1:0] S_DISP = MODE_W'(NUM_ENG + 2);
  localparam logic [TO_W-1:0]   WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   WD_MAX  = {TO_W{1'b1}};

  logic [MODE_W-1:0]  mode_r;
  logic [NUM_ENG-1:0] mask_r;
  logic [TO_W-1:0]    wd_r;
  logic               en_mem_r;
  logic [NUM_ENG-1:0] en_eng_r;
  logic               en_disp_r;
  logic               busy_r;
  logic               run_done_r;
  logic               err_r;
  logic [MODE_W-1:0]  err_mode_r;

  logic               done_s;
  logic               expire_s;
  logic               advance_s;
  logic               forced_s;
  logic [MODE_W-1:0]  next_s;

  // Lowest unskipped engine at or above 'first', or DISP when none remain.
  function automatic logic [MODE_W-1:0] next_engine(input logic [NUM_ENG-1:0] mask,
                                                    input int first);
    logic [MODE_W-1:0] m;
    m = S_DISP;
    for (int j = NUM_ENG - 1; j >= 0; j--) begin
      m = ((j >= first) && !mask[j]) ? MODE_W'(j + 2) : m;
    end
    return m;
  endfunction

  function automatic logic [NUM_ENG-1:0] eng_onehot(input logic [MODE_W-1:0] m);
    logic [NUM_ENG-1:0] oh;
    for (int k = 0; k < NUM_ENG; k++) begin
      oh[k] = (m == MODE_W'(k + 2));
    end
    return oh;
  endfunction

  // Select the handshake relevant to the current mode and the mode that follows it.
  always_comb begin
    done_s = 1'b0;
    next_s = S_IDLE;
    case (mode_r)
      S_IDLE: begin
        done_s = bus.start;
        next_s = S_MEM;
      end
      S_MEM: begin
        done_s = bus.mem_done;
        next_s = next_engine(mask_r, 0);
      end
      S_DISP: begin
        done_s = bus.disp_ack;
        next_s = S_IDLE;
      end
      default: begin
        for (int k = 0; k < NUM_ENG; k++) begin
          done_s = (mode_r == MODE_W'(k + 2)) ? bus.eng_done[k] : done_s;
          next_s = (mode_r == MODE_W'(k + 2)) ? next_engine(mask_r, k + 1) : next_s;
        end
      end
    endcase
    expire_s  = (mode_r != S_IDLE) && (wd_r == WD_LAST);
    advance_s = done_s || expire_s;
    forced_s  = expire_s && !done_s;
  end

  // Mode register, watchdog, decoded enables and error capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r     <= S_IDLE;
      mask_r     <= '0;
      wd_r       <= '0;
      en_mem_r   <= 1'b0;
      en_eng_r   <= '0;
      en_disp_r  <= 1'b0;
      busy_r     <= 1'b0;
      run_done_r <= 1'b0;
      err_r      <= 1'b0;
      err_mode_r <= '0;
    end else begin
      run_done_r <= 1'b0;
      if (advance_s) begin
        mode_r     <= next_s;
        wd_r       <= '0;
        en_mem_r   <= (next_s == S_MEM);
        en_eng_r   <= eng_onehot(next_s);
        en_disp_r  <= (next_s == S_DISP);
        busy_r     <= (next_s != S_IDLE);
        run_done_r <= (mode_r == S_DISP);
      end else if ((mode_r != S_IDLE) && (wd_r != WD_MAX)) begin
        wd_r <= wd_r + TO_W'(1);
      end else begin
        wd_r <= wd_r;
      end

      // Only the first expiry since the accepted start names the failing mode.
      if ((mode_r == S_IDLE) && bus.start) begin
        mask_r     <= bus.skip_mask;
        err_r      <= 1'b0;
        err_mode_r <= '0;
      end else if (forced_s) begin
        err_r      <= 1'b1;
        err_mode_r <= err_r ? err_mode_r : mode_r;
      end else begin
        err_r      <= err_r;
        err_mode_r <= err_mode_r;
      end
    end
  end

  assign bus.mode_num    = mode_r;
  assign bus.en_mem      = en_mem_r;
  assign bus.en_eng      = en_eng_r;
  assign bus.en_disp     = en_disp_r;
  assign bus.busy        = busy_r;
  assign bus.run_done    = run_done_r;
  assign bus.timeout_err = err_r;
  assign bus.err_mode    = err_mode_r;
endmodule

// File: tb/tb_engine_mode_sequencer.sv
// Bench for engine_mode_sequencer: directed scenarios plus randomized runs, all checked
// every cycle against a run-plan model (a queue of modes built when a run is accepted).
module tb_engine_mode_sequencer;
  localparam int NE = 3;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  engine_mode_sequencer_if #(.NUM_ENG(NE)) bus ();
  engine_mode_sequencer #(.NUM_ENG(NE), .TO_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: current mode, remaining plan, cycles spent in mode, error record.
  int m_mode, m_wd, m_err_mode;
  bit m_err, m_run_done;
  int plan[$];
  bit chk_en = 1'b0;

  int dwell[0:7];
  int seq[$];
  int exp_q[$];
  int mode_cnt[0:7];
  logic [NE-1:0] eng_seen;
  int rd_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wd = 0; m_err = 1'b0; m_err_mode = 0; m_run_done = 1'b0;
    plan.delete();
  endtask

  task automatic model_step(input bit st, input logic [NE-1:0] msk, input bit md,
                            input logic [NE-1:0] ed, input bit da);
    m_run_done = 1'b0;
    if (m_mode == 0) begin
      if (st) begin
        plan.delete();
        for (int k = 0; k < NE; k++) if (!msk[k]) plan.push_back(k + 2);
        plan.push_back(NE + 2);
        m_mode = 1; m_wd = 0; m_err = 1'b0; m_err_mode = 0;
      end
    end else begin
      bit d;
      if (m_mode == 1) d = md;
      else if (m_mode == NE + 2) d = da;
      else d = ed[m_mode - 2];
      if (d || (m_wd == TO - 1)) begin
        if (!d) begin
          if (!m_err) m_err_mode = m_mode;
          m_err = 1'b1;
        end
        if (m_mode == NE + 2) begin
          m_mode = 0;
          m_run_done = 1'b1;
        end else begin
          m_mode = plan.pop_front();
        end
        m_wd = 0;
      end else begin
        m_wd++;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NE-1:0] oh;
    if (chk_en) begin
      oh = '0;
      if (m_mode >= 2 && m_mode <= NE + 1) oh[m_mode - 2] = 1'b1;
      chk("mode_num", int'(bus.mode_num), m_mode);
      chk("en_mem", int'(bus.en_mem), int'(m_mode == 1));
      chk("en_eng", int'(bus.en_eng), int'(oh));
      chk("en_disp", int'(bus.en_disp), int'(m_mode == NE + 2));
      chk("busy", int'(bus.busy), int'(m_mode != 0));
      chk("run_done", int'(bus.run_done), int'(m_run_done));
      chk("timeout_err", int'(bus.timeout_err), int'(m_err));
      chk("err_mode", int'(bus.err_mode), m_err_mode);
    end
  end

  task automatic cyc(input bit st, input logic [NE-1:0] msk, input bit md,
                     input logic [NE-1:0] ed, input bit da);
    @(negedge clk);
    #1;
    bus.start = st; bus.skip_mask = msk; bus.mem_done = md; bus.eng_done = ed; bus.disp_ack = da;
    @(posedge clk);
    if (rst) model_step(st, msk, md, ed, da);
  endtask

  // Drive one run: each mode's done/ack rises once the mode has lasted dwell[mode] cycles.
  task automatic run_auto(input logic [NE-1:0] msk, input bit noise, input bit do_start);
    int budget;
    logic [NE-1:0] ed, mk;
    bit md, da, st, go;
    seq.delete();
    seq.push_back(m_mode);
    for (int i = 0; i < 8; i++) mode_cnt[i] = 0;
    eng_seen = '0;
    rd_cnt = 0;
    if (do_start) begin
      cyc(1'b1, msk, 1'b0, '0, 1'b0);
      #1;
      seq.push_back(m_mode);
    end
    budget = 0;
    while (m_mode != 0 && budget < 3000) begin
      mode_cnt[m_mode]++;
      go = (m_wd >= dwell[m_mode]);
      st = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mk = noise ? NE'($urandom) : msk;
      ed = noise ? NE'($urandom) : '0;
      md = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      da = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_mode == 1) md = go;
      else if (m_mode == NE + 2) da = go;
      else ed[m_mode - 2] = go;
      cyc(st, mk, md, ed, da);
      #1;
      eng_seen |= bus.en_eng;
      rd_cnt += int'(bus.run_done);
      if (m_mode != seq[seq.size() - 1]) seq.push_back(m_mode);
      budget++;
    end
    if (m_mode != 0) chk("run_budget", m_mode, 0);
  endtask

  task automatic check_seq(input string name);
    bit ok;
    ok = (seq.size() == exp_q.size());
    if (ok) for (int i = 0; i < seq.size(); i++) if (seq[i] != exp_q[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d modes (last %0d), expected %0d modes (last %0d)", name,
               seq.size(), seq[seq.size() - 1], exp_q.size(), exp_q[exp_q.size() - 1]);
    end
  endtask

  task automatic set_dwell(input int v);
    for (int i = 0; i < 8; i++) dwell[i] = v;
  endtask

  initial begin
    bus.start = 1'b0; bus.skip_mask = '0; bus.mem_done = 1'b0; bus.eng_done = '0;
    bus.disp_ack = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_mode", int'(bus.mode_num), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Full run, no skips, every handshake 3 cycles after entry.
    set_dwell(3);
    run_auto(3'b000, 1'b0, 1'b1);
    exp_q = {0, 1, 2, 3, 4, 5, 0};
    check_seq("t1_seq");
    chk("t1_run_done_pulses", rd_cnt, 1);
    chk("t1_timeout_err", int'(bus.timeout_err), 0);
    chk("t1_eng_seen", int'(eng_seen), 7);

    // Engine 1 skipped.
    run_auto(3'b010, 1'b0, 1'b1);
    exp_q = {0, 1, 2, 4, 5, 0};
    check_seq("t2_seq");
    chk("t2_no_eng1", int'(eng_seen[1]), 0);

    // All engines skipped.
    run_auto(3'b111, 1'b0, 1'b1);
    exp_q = {0, 1, 5, 0};
    check_seq("t3_seq");
    chk("t3_eng_seen", int'(eng_seen), 0);

    // Engines 0 and 1 never finish: two expiries, first one recorded.
    set_dwell(3);
    dwell[2] = 999;
    dwell[3] = 999;
    run_auto(3'b000, 1'b0, 1'b1);
    exp_q = {0, 1, 2, 3, 4, 5, 0};
    check_seq("t4_seq");
    chk("t4_mode2_cycles", mode_cnt[2], 200);
    chk("t4_mode3_cycles", mode_cnt[3], 200);
    chk("t4_timeout_err", int'(bus.timeout_err), 1);
    chk("t4_err_mode", int'(bus.err_mode), 2);
    set_dwell(2);
    cyc(1'b1, 3'b000, 1'b0, '0, 1'b0);
    #1;
    chk("t4_err_cleared", int'(bus.timeout_err), 0);
    chk("t4_err_mode_cleared", int'(bus.err_mode), 0);
    run_auto(3'b000, 1'b0, 1'b0);

    // Spurious start and wrong engine done in ENG_0, then reset in ENG_1.
    cyc(1'b1, 3'b000, 1'b0, '0, 1'b0);
    cyc(1'b0, 3'b000, 1'b1, '0, 1'b0);
    cyc(1'b1, 3'b111, 1'b0, 3'b100, 1'b0);
    #1;
    chk("t5_hold_mode", int'(bus.mode_num), 2);
    chk("t5_hold_en", int'(bus.en_eng), 1);
    cyc(1'b0, 3'b000, 1'b0, 3'b001, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t5_in_eng1", int'(bus.mode_num), 3);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_mode", int'(bus.mode_num), 0);
    chk("t5_rst_en_eng", int'(bus.en_eng), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_run_done", int'(bus.run_done), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    // mem_done on the exact expiry cycle is a normal advance.
    set_dwell(3);
    dwell[1] = TO - 1;
    run_auto(3'b000, 1'b0, 1'b1);
    chk("t6_mem_cycles", mode_cnt[1], 200);
    chk("t6_timeout_err", int'(bus.timeout_err), 0);

    // Randomized runs with noise on every unrelated input.
    for (int r = 0; r < 40; r++) begin
      logic [NE-1:0] msk;
      msk = NE'($urandom);
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 9))
          0: dwell[i] = 999;
          1: dwell[i] = TO - 1;
          default: dwell[i] = $urandom_range(0, 5);
        endcase
      end
      run_auto(msk, 1'b1, 1'b1);
      chk("rnd_skip_en", int'(eng_seen & msk), 0);
      repeat ($urandom_range(0, 3))
        cyc(1'b0, NE'($urandom), 1'($urandom_range(0, 1)), NE'($urandom),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
